// File: rtl/game_sequencer.sv
// Round controller for the PalmPilot X game: leaderboard, difficulty select, get-ready
// countdown, timed play with pause, win/lost hold and return, plus 1 Hz prescaler and score latch.
module game_sequencer #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int NUM_LEVELS  = 3,
    parameter int LVL_W       = 2,
    parameter int TIME_W      = 10,
    parameter logic [NUM_LEVELS*TIME_W-1:0] TIME_LIMITS = {10'd180, 10'd300, 10'd420},
    parameter int WARN_OFS    = 120,
    parameter int CRIT_OFS    = 60,
    parameter int GET_READY_S = 5,
    parameter int DELAY_S     = 3,
    parameter int SCORE_W     = 10
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               start,
    input  logic               sel_valid,
    input  logic [LVL_W-1:0]   sel_level,
    input  logic               win,
    input  logic               pause,
    output logic [2:0]         state,
    output logic [3:0]         countdown,
    output logic [TIME_W-1:0]  elapsed_s,
    output logic [LVL_W-1:0]   level,
    output logic               warn,
    output logic               critical,
    output logic [SCORE_W-1:0] score,
    output logic               score_valid
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_PLAY   = 3'd3;
    localparam logic [2:0] S_PAUSE  = 3'd4;
    localparam logic [2:0] S_WIN    = 3'd5;
    localparam logic [2:0] S_LOST   = 3'd6;

    localparam int PS_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SAT_W = (TIME_W > SCORE_W) ? TIME_W : SCORE_W;
    localparam logic [PS_W-1:0]  PS_MAX       = PS_W'(CLK_HZ - 1);
    localparam logic [SAT_W-1:0] SCORE_MAX    = SAT_W'({SCORE_W{1'b1}});
    localparam logic [LVL_W:0]   NUM_LEVELS_W = (LVL_W + 1)'(NUM_LEVELS);
    localparam logic [3:0]       READY_LOAD   = 4'(GET_READY_S);
    localparam logic [3:0]       HOLD_LOAD    = 4'(DELAY_S);
    localparam logic [31:0]      WARN_OFS_U   = 32'(WARN_OFS);
    localparam logic [31:0]      CRIT_OFS_U   = 32'(CRIT_OFS);

    logic [PS_W-1:0]    prescaler, next_prescaler;
    logic               counting, tick, keep_phase;
    logic [TIME_W-1:0]  limit, elapsed_inc, warn_thr, crit_thr;
    logic [31:0]        limit_wide;
    logic [SAT_W-1:0]   elapsed_wide;
    logic [SCORE_W-1:0] score_sat;
    logic [2:0]         next_state;
    logic [3:0]         next_countdown;
    logic [TIME_W-1:0]  next_elapsed;
    logic [LVL_W-1:0]   next_level;
    logic [SCORE_W-1:0] next_score;
    logic               next_score_valid, next_warn, next_critical, in_play;

    always_comb begin
        limit = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (level == LVL_W'(i)) begin
                limit = TIME_LIMITS[i*TIME_W +: TIME_W];
            end
        end
    end

    // Zone thresholds clamp at zero when the offset is larger than the level's limit.
    always_comb begin
        limit_wide   = 32'(limit);
        warn_thr     = (limit_wide > WARN_OFS_U) ? TIME_W'(limit_wide - WARN_OFS_U) : '0;
        crit_thr     = (limit_wide > CRIT_OFS_U) ? TIME_W'(limit_wide - CRIT_OFS_U) : '0;
        elapsed_inc  = (elapsed_s == '1) ? elapsed_s : elapsed_s + TIME_W'(1);
        elapsed_wide = SAT_W'(elapsed_s);
        score_sat    = (elapsed_wide > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(elapsed_wide);
        counting     = (state == S_READY) || (state == S_PLAY) || (state == S_WIN) || (state == S_LOST);
        tick         = counting && (prescaler == PS_MAX);
    end

    always_comb begin
        next_state     = state;
        next_countdown = countdown;
        next_elapsed   = elapsed_s;
        next_level     = level;
        next_score     = score;

        case (state)
            S_IDLE: begin
                next_elapsed   = '0;
                next_countdown = '0;
                if (start) begin
                    next_state = S_SELECT;
                end
            end
            S_SELECT: begin
                if (sel_valid && ({1'b0, sel_level} < NUM_LEVELS_W)) begin
                    next_level     = sel_level;
                    next_countdown = READY_LOAD;
                    next_state     = S_READY;
                end
            end
            S_READY: begin
                if (tick) begin
                    if (countdown <= 4'd1) begin
                        next_state     = S_PLAY;
                        next_countdown = '0;
                        next_elapsed   = '0;
                    end else begin
                        next_countdown = countdown - 4'd1;
                    end
                end
            end
            S_PLAY: begin
                // A win beats a timeout landing on the same cycle; the score is the pre-tick time.
                if (win) begin
                    next_state     = S_WIN;
                    next_score     = score_sat;
                    next_countdown = HOLD_LOAD;
                end else if (tick && (elapsed_inc == limit)) begin
                    next_state     = S_LOST;
                    next_elapsed   = elapsed_inc;
                    next_countdown = HOLD_LOAD;
                end else begin
                    if (tick) begin
                        next_elapsed = elapsed_inc;
                    end
                    if (pause) begin
                        next_state = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (!pause) begin
                    next_state = S_PLAY;
                end
            end
            S_WIN, S_LOST: begin
                if (tick) begin
                    if (countdown <= 4'd1) begin
                        next_state     = S_IDLE;
                        next_countdown = '0;
                    end else begin
                        next_countdown = countdown - 4'd1;
                    end
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        if ((state != S_IDLE) && !start) begin
            next_state     = S_IDLE;
            next_countdown = '0;
            next_score     = score;
        end
    end

    // Pausing and resuming keeps the prescaler phase; every other state entry restarts the second.
    always_comb begin
        keep_phase = ((state == S_PLAY) && (next_state == S_PAUSE)) ||
                     ((state == S_PAUSE) && (next_state == S_PLAY));
        if ((next_state != state) && !keep_phase) begin
            next_prescaler = '0;
        end else if (state == S_PAUSE) begin
            next_prescaler = prescaler;
        end else if (counting) begin
            next_prescaler = tick ? '0 : prescaler + PS_W'(1);
        end else begin
            next_prescaler = '0;
        end

        in_play          = (next_state == S_PLAY) || (next_state == S_PAUSE);
        next_critical    = in_play && (next_elapsed >= crit_thr);
        next_warn        = in_play && (next_elapsed >= warn_thr) && !next_critical;
        next_score_valid = (next_state == S_WIN) && (state != S_WIN);
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state       <= S_IDLE;
            prescaler   <= '0;
            countdown   <= '0;
            elapsed_s   <= '0;
            level       <= '0;
            warn        <= 1'b0;
            critical    <= 1'b0;
            score       <= '0;
            score_valid <= 1'b0;
        end else begin
            state       <= next_state;
            prescaler   <= next_prescaler;
            countdown   <= next_countdown;
            elapsed_s   <= next_elapsed;
            level       <= next_level;
            warn        <= next_warn;
            critical    <= next_critical;
            score       <= next_score;
            score_valid <= next_score_valid;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed screen-flow scenarios plus randomized rounds
// checked against a cycle-counting model of the round timing rules.
module tb_game_sequencer;

    localparam int CLK = 10;
    localparam int DLY = 2;

    logic       clk_100MHz = 1'b0;
    logic       reset, start, sel_valid, win, pause;
    logic [1:0] sel_level;
    logic [2:0] state;
    logic [3:0] countdown;
    logic [9:0] elapsed_s;
    logic [1:0] level;
    logic       warn, critical;
    logic [9:0] score;
    logic       score_valid;

    int total = 0;
    int bad   = 0;

    int m_state, m_play, m_hold, m_score, m_lvl;
    bit m_sv;
    int lim_tab [3] = '{3, 6, 9};

    game_sequencer #(
        .CLK_HZ(CLK), .NUM_LEVELS(3), .LVL_W(2), .TIME_W(10),
        .TIME_LIMITS({10'd9, 10'd6, 10'd3}), .WARN_OFS(2), .CRIT_OFS(1),
        .GET_READY_S(2), .DELAY_S(DLY), .SCORE_W(10)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .start(start), .sel_valid(sel_valid),
        .sel_level(sel_level), .win(win), .pause(pause), .state(state),
        .countdown(countdown), .elapsed_s(elapsed_s), .level(level), .warn(warn),
        .critical(critical), .score(score), .score_valid(score_valid)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic step();
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
    endtask

    // Reference: elapsed seconds are whole CLK-cycle blocks spent in PLAY, holds are DLY*CLK cycles.
    function automatic int m_elapsed();
        return m_play / CLK;
    endfunction

    function automatic int thr(input int ofs);
        int l;
        l = lim_tab[m_lvl];
        return (l > ofs) ? l - ofs : 0;
    endfunction

    function automatic bit exp_crit();
        return ((m_state == 3) || (m_state == 4)) && (m_elapsed() >= thr(1));
    endfunction

    function automatic bit exp_warn();
        return ((m_state == 3) || (m_state == 4)) && (m_elapsed() >= thr(2)) && !exp_crit();
    endfunction

    function automatic int exp_cd();
        return ((m_state == 5) || (m_state == 6)) ? DLY - m_hold / CLK : 0;
    endfunction

    task automatic model_step(input bit p, input bit w);
        int e;
        bit tk;
        m_sv = 1'b0;
        case (m_state)
            3: begin
                e  = m_play / CLK;
                tk = (m_play % CLK) == CLK - 1;
                if (w) begin
                    m_state = 5; m_score = e; m_sv = 1'b1; m_hold = 0;
                end else if (tk && (e + 1 == lim_tab[m_lvl])) begin
                    m_play++; m_state = 6; m_hold = 0;
                end else begin
                    m_play++;
                    if (p) m_state = 4;
                end
            end
            4: if (!p) m_state = 3;
            5, 6: begin
                m_hold++;
                if (m_hold == DLY * CLK) m_state = 0;
            end
            default: ;
        endcase
    endtask

    task automatic go_to_play(input int lvl);
        pause = 1'b0; win = 1'b0; sel_valid = 1'b0;
        start = 1'b0; step();
        start = 1'b1; step();
        sel_level = 2'(lvl); sel_valid = 1'b1; step();
        sel_valid = 1'b0;
        repeat (2 * CLK) step();
        m_state = 3; m_play = 0; m_hold = 0; m_lvl = lvl; m_sv = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sel_valid = 1'b0; sel_level = 2'd0; win = 1'b0; pause = 1'b0;
        repeat (3) step();
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", state); end
        total++; if (countdown !== 4'd0) begin bad++; $display("[TB] FAIL reset_countdown got=%0d want=0", countdown); end
        total++; if (elapsed_s !== 10'd0) begin bad++; $display("[TB] FAIL reset_elapsed got=%0d want=0", elapsed_s); end
        total++; if (level !== 2'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", level); end
        total++; if ({warn, critical} !== 2'b00) begin bad++; $display("[TB] FAIL reset_zone got=%b want=00", {warn, critical}); end
        total++; if (score !== 10'd0) begin bad++; $display("[TB] FAIL reset_score got=%0d want=0", score); end
        total++; if (score_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_score_valid got=%b want=0", score_valid); end
        reset = 1'b0;
        step();
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL idle_hold got=%0d want=0", state); end
    endtask

    task automatic test_select();
        start = 1'b1; step();
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL enter_select got=%0d want=1", state); end
        sel_level = 2'd3; sel_valid = 1'b1; step(); sel_valid = 1'b0;
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL bad_level_state got=%0d want=1", state); end
        total++; if (level !== 2'd0) begin bad++; $display("[TB] FAIL bad_level_latch got=%0d want=0", level); end
        sel_level = 2'd1; sel_valid = 1'b1; step(); sel_valid = 1'b0;
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL enter_ready got=%0d want=2", state); end
        total++; if (level !== 2'd1) begin bad++; $display("[TB] FAIL level_latch got=%0d want=1", level); end
        total++; if (countdown !== 4'd2) begin bad++; $display("[TB] FAIL ready_cd_start got=%0d want=2", countdown); end
        repeat (CLK - 1) step();
        total++; if (countdown !== 4'd2) begin bad++; $display("[TB] FAIL ready_cd_early got=%0d want=2", countdown); end
        step();
        total++; if (countdown !== 4'd1) begin bad++; $display("[TB] FAIL ready_cd_tick got=%0d want=1", countdown); end
        repeat (CLK - 1) step();
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL ready_still got=%0d want=2", state); end
        step();
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL enter_play got=%0d want=3", state); end
        total++; if ({countdown, elapsed_s} !== 14'd0) begin bad++; $display("[TB] FAIL play_start_vals got=%0d/%0d want=0/0", countdown, elapsed_s); end
        start = 1'b0; step();
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL abort_play got=%0d want=0", state); end
    endtask

    task automatic test_timeout();
        go_to_play(0);
        repeat (CLK) step();
        total++; if ({elapsed_s, warn, critical} !== {10'd1, 2'b10}) begin bad++; $display("[TB] FAIL warn_zone got=%0d,%b%b want=1,10", elapsed_s, warn, critical); end
        repeat (CLK) step();
        total++; if ({elapsed_s, warn, critical} !== {10'd2, 2'b01}) begin bad++; $display("[TB] FAIL crit_zone got=%0d,%b%b want=2,01", elapsed_s, warn, critical); end
        repeat (CLK - 1) step();
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL pre_timeout got=%0d want=3", state); end
        step();
        total++; if (state !== 3'd6) begin bad++; $display("[TB] FAIL lost_state got=%0d want=6", state); end
        total++; if (elapsed_s !== 10'd3) begin bad++; $display("[TB] FAIL lost_elapsed got=%0d want=3", elapsed_s); end
        total++; if ({countdown, warn, critical} !== {4'd2, 2'b00}) begin bad++; $display("[TB] FAIL lost_outputs got=%0d,%b%b want=2,00", countdown, warn, critical); end
        repeat (2 * CLK - 1) step();
        total++; if (state !== 3'd6) begin bad++; $display("[TB] FAIL lost_hold got=%0d want=6", state); end
        step();
        total++; if ({state, countdown} !== {3'd0, 4'd0}) begin bad++; $display("[TB] FAIL lost_return got=%0d,%0d want=0,0", state, countdown); end
    endtask

    task automatic test_win();
        go_to_play(2);
        repeat (4 * CLK) step();
        total++; if (elapsed_s !== 10'd4) begin bad++; $display("[TB] FAIL win_pre_elapsed got=%0d want=4", elapsed_s); end
        win = 1'b1; step(); win = 1'b0;
        total++; if (state !== 3'd5) begin bad++; $display("[TB] FAIL win_state got=%0d want=5", state); end
        total++; if ({score, score_valid} !== {10'd4, 1'b1}) begin bad++; $display("[TB] FAIL win_score got=%0d,%b want=4,1", score, score_valid); end
        step();
        total++; if ({score, score_valid} !== {10'd4, 1'b0}) begin bad++; $display("[TB] FAIL win_pulse got=%0d,%b want=4,0", score, score_valid); end
        start = 1'b0; step();
        total++; if ({state, score} !== {3'd0, 10'd4}) begin bad++; $display("[TB] FAIL abort_keep_score got=%0d,%0d want=0,4", state, score); end
    endtask

    task automatic test_pause();
        go_to_play(2);
        repeat (CLK + 3) step();
        pause = 1'b1;
        step();
        total++; if ({state, elapsed_s} !== {3'd4, 10'd1}) begin bad++; $display("[TB] FAIL pause_entry got=%0d,%0d want=4,1", state, elapsed_s); end
        repeat (36) step();
        total++; if ({state, elapsed_s} !== {3'd4, 10'd1}) begin bad++; $display("[TB] FAIL pause_frozen got=%0d,%0d want=4,1", state, elapsed_s); end
        pause = 1'b0;
        step();
        repeat (5) step();
        total++; if ({state, elapsed_s} !== {3'd3, 10'd1}) begin bad++; $display("[TB] FAIL resume_phase got=%0d,%0d want=3,1", state, elapsed_s); end
        step();
        total++; if (elapsed_s !== 10'd2) begin bad++; $display("[TB] FAIL resume_tick got=%0d want=2", elapsed_s); end
    endtask

    task automatic test_win_timeout_reset();
        go_to_play(0);
        repeat (3 * CLK - 1) step();
        total++; if ({state, elapsed_s} !== {3'd3, 10'd2}) begin bad++; $display("[TB] FAIL race_pre got=%0d,%0d want=3,2", state, elapsed_s); end
        win = 1'b1; step(); win = 1'b0;
        total++; if ({state, score, score_valid} !== {3'd5, 10'd2, 1'b1}) begin bad++; $display("[TB] FAIL race_win got=%0d,%0d,%b want=5,2,1", state, score, score_valid); end
        step();
        reset = 1'b1; step();
        total++; if ({state, countdown, elapsed_s, level, warn, critical, score, score_valid} !== 33'd0) begin
            bad++; $display("[TB] FAIL reset_in_win got=%0d,%0d,%0d,%0d,%b%b,%0d,%b want=all 0", state, countdown, elapsed_s, level, warn, critical, score, score_valid);
        end
        reset = 1'b0; start = 1'b0; step();
    endtask

    task automatic test_random();
        int  lvl, win_at;
        bit  p, w, done;
        m_score = 0;
        for (int r = 0; r < 6; r++) begin
            lvl = $urandom_range(0, 2);
            go_to_play(lvl);
            total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL rnd_enter r=%0d got=%0d want=3", r, state); end
            win_at = $urandom_range(1, lim_tab[lvl] * CLK * 2);
            p = 1'b0; done = 1'b0;
            for (int c = 0; c < 1000 && !done; c++) begin
                if ($urandom_range(0, 7) == 0) p = ~p;
                w = (c == win_at);
                pause = p; win = w;
                step();
                model_step(p, w);
                total++; if (state !== 3'(m_state)) begin bad++; $display("[TB] FAIL rnd_state r=%0d c=%0d got=%0d want=%0d", r, c, state, m_state); end
                total++; if (countdown !== 4'(exp_cd())) begin bad++; $display("[TB] FAIL rnd_countdown r=%0d c=%0d got=%0d want=%0d", r, c, countdown, exp_cd()); end
                total++; if ({warn, critical} !== {exp_warn(), exp_crit()}) begin bad++; $display("[TB] FAIL rnd_zone r=%0d c=%0d got=%b%b want=%b%b", r, c, warn, critical, exp_warn(), exp_crit()); end
                total++; if ({score, score_valid} !== {10'(m_score), m_sv}) begin bad++; $display("[TB] FAIL rnd_score r=%0d c=%0d got=%0d,%b want=%0d,%b", r, c, score, score_valid, m_score, m_sv); end
                if ((m_state == 3) || (m_state == 4) || (m_state == 6)) begin
                    total++; if (elapsed_s !== 10'(m_elapsed())) begin bad++; $display("[TB] FAIL rnd_elapsed r=%0d c=%0d got=%0d want=%0d", r, c, elapsed_s, m_elapsed()); end
                end
                if (m_state == 0) done = 1'b1;
            end
            pause = 1'b0; win = 1'b0;
            total++; if (!done) begin bad++; $display("[TB] FAIL rnd_round_timeout r=%0d got=state %0d want=round end", r, state); end
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_timeout();
        test_win();
        test_pause();
        test_win_timeout_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
